test_probe_ctrl: RTL and testbench
==================================

// Module: test_probe_ctrl
// PURPOSE
//  Parametrised successor to the fixed 8:1 test MUX/DEMUX observation fabric around the MSK TX/RX chain.
//  Selects one of NUM_CH internal probe buses through a serially loaded configuration word, using 3 pins.
//  Drives the selected bus live (registered), or captures it into an on-chip DEPTH-entry snapshot buffer.
//  The buffer is read out later at pin speed.
// PARAMETERS
//  NUM_CH  8   number of probe channels (>=2)
//  DATA_W  4   width of each probe channel in bits
//  DEPTH   16  snapshot buffer entries (power of 2)
//  SEL_W   $clog2(NUM_CH)  derived (localparam); CFG_W = SEL_W+2
// PORTS
//  inClock          in   1               single clock; all logic rising-edge
//  inReset          in   1               synchronous, active-high reset
//  inCfgShift       in   1               shift inCfgData into shadow config register
//  inCfgData        in   1               serial config bit, MSB first
//  inCfgLoad        in   1               copy shadow config into active config
//  inProbeData      in   NUM_CH*DATA_W   channel k = bits [k*DATA_W +: DATA_W]
//  inProbeValid     in   NUM_CH          per-channel sample strobe
//  inArm            in   1               start a capture
//  inReadEnable     in   1               pop one buffer entry
//  outProbe         out  DATA_W          live registered view of the selected channel
//  outProbeValid    out  1               registered inProbeValid[sel]
//  outData          out  DATA_W          buffer read data
//  outEmpty         out  1               buffer empty
//  outFull          out  1               buffer holds DEPTH entries
//  outCount         out  $clog2(DEPTH)+1 entries in buffer
//  outCapturing     out  1               FSM in CAPT
//  outDone          out  1               FSM in DONE
//  outError         out  1               1-cycle pulse on an illegal request
// BEHAVIOUR
//  Reset: every output is 0 except outEmpty=1. shadow=0, active cfg=0 (sel=0, mode=BYPASS), FSM=IDLE, pointers=0.
//  Config: cfg = {mode[1:0], sel[SEL_W-1:0]}.
//   - inCfgShift: shadow <= {shadow[CFG_W-2:0], inCfgData}.
//   - inCfgLoad: active <= shadow (pre-shift value if inCfgShift is also high that cycle).
//   - sel >= NUM_CH at load: load rejected, outError pulse.
//   - inCfgLoad while CAPT: ignored, outError pulse.
//  Modes:
//   - 00 BYPASS: no capture.
//   - 01 CAPT_VALID: write the selected channel when inProbeValid[sel]=1.
//   - 10 CAPT_ALL: write the selected channel every cycle.
//   - 11 FREEZE: outProbe/outProbeValid hold their last value.
//  Live path: outProbe <= inProbeData[sel]; outProbeValid <= inProbeValid[sel]. Latency 1 cycle.
//   - A sel change takes effect the cycle after the load.
//  FSM IDLE/CAPT/DONE:
//   - IDLE --inArm & mode in {01,10}--> CAPT. wr_ptr, rd_ptr and count clear the same cycle.
//   - inArm in IDLE/DONE with mode 00/11: stay, outError pulse.
//   - CAPT --count reaches DEPTH--> DONE. The DEPTH-th write and the transition happen on the same edge.
//   - CAPT: inArm is ignored; inReadEnable is ignored with an outError pulse.
//   - DONE --inArm--> CAPT (buffer cleared). Reading DONE to empty leaves the FSM in DONE.
//  Capture: the write samples the same-cycle inProbeData[sel]. The first eligible sample is the cycle after inArm.
//  Readout (IDLE or DONE): inReadEnable & !outEmpty -> outData <= mem[rd_ptr], rd_ptr++, count--. Latency 1 cycle.
//   - Read when empty: outData holds, outError pulse.
//  Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count saturates at DEPTH; there are no writes past full.
//  outFull = (count==DEPTH); outEmpty = (count==0).
//  Reset mid-capture or mid-readout: immediate return to reset state on the next edge. Buffer contents are don't-care.
// TESTING
//  T1 reset: hold inReset 2 cycles -> outEmpty=1, all other outputs 0, outProbe=0 with ch0 driven 4'hA.
//  T2 bypass: shift cfg 5'b00_011 MSB first, pulse load; ch3=4'h5 -> outProbe=4'h5 one cycle later.
//     Then load sel=3'd7 -> ch7 visible next cycle.
//  T3 CAPT_ALL: cfg 5'b10_010, ch2 ramps 0..F, arm.
//     -> outCapturing for 16 cycles, then outDone=1, outFull=1.
//     16 reads return 0..F in order, then outEmpty=1, outCount=0.
//  T4 CAPT_VALID: cfg 5'b01_001, valid on every 3rd cycle with data 1,2,3.
//     -> outCount increments only on valid. Readout 1,2,3 after the buffer fills.
//  T5 errors: cfg load during CAPT, read during CAPT, read when empty, arm in BYPASS.
//     -> each gives exactly a 1-cycle outError; state is unchanged.
//  T6 reset mid-capture after 7 writes -> next cycle IDLE, outCount=0, active cfg=0.
//     Re-arm after reconfig captures a fresh 16.

Source files
------------

// File: rtl/test_probe_ctrl.sv
// Probe observation fabric: serially configured channel select, live registered view,
// and a DEPTH-entry snapshot buffer that is read out afterwards at pin speed.
module test_probe_ctrl #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic                       inClock,
    input  logic                       inReset,
    input  logic                       inCfgShift,
    input  logic                       inCfgData,
    input  logic                       inCfgLoad,
    input  logic [NUM_CH*DATA_W-1:0]   inProbeData,
    input  logic [NUM_CH-1:0]          inProbeValid,
    input  logic                       inArm,
    input  logic                       inReadEnable,
    output logic [DATA_W-1:0]          outProbe,
    output logic                       outProbeValid,
    output logic [DATA_W-1:0]          outData,
    output logic                       outEmpty,
    output logic                       outFull,
    output logic [$clog2(DEPTH):0]     outCount,
    output logic                       outCapturing,
    output logic                       outDone,
    output logic                       outError
);

    localparam int SEL_W = $clog2(NUM_CH);
    localparam int CFG_W = SEL_W + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [SEL_W:0]     NUM_CH_L   = (SEL_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0]   LAST_WRITE = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   DEPTH_CNT  = CNT_W'(DEPTH);

    localparam logic [1:0] MODE_BYPASS     = 2'b00;
    localparam logic [1:0] MODE_CAPT_VALID = 2'b01;
    localparam logic [1:0] MODE_CAPT_ALL   = 2'b10;
    localparam logic [1:0] MODE_FREEZE     = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CAPT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [CFG_W-1:0]   shadow_reg;
    logic [1:0]         mode_reg;
    logic [SEL_W-1:0]   sel_reg;
    logic [1:0]         state_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [DATA_W-1:0]  probe_reg;
    logic               probe_valid_reg;
    logic [DATA_W-1:0]  data_reg;
    logic               error_reg;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  ch_data [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_data[gi] = inProbeData[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [DATA_W-1:0]  sel_data;
    logic               sel_valid;
    logic               in_capt;
    logic               capt_mode;
    logic               cfg_sel_ok;
    logic               arm_ok;
    logic               write_en;
    logic               read_en;
    logic               buf_empty;
    logic               error_next;

    assign sel_data   = ch_data[sel_reg];
    assign sel_valid  = inProbeValid[sel_reg];
    assign in_capt    = (state_reg == ST_CAPT);
    assign capt_mode  = (mode_reg == MODE_CAPT_VALID) || (mode_reg == MODE_CAPT_ALL);
    assign cfg_sel_ok = ({1'b0, shadow_reg[SEL_W-1:0]} < NUM_CH_L);
    assign buf_empty  = (count_reg == '0);
    assign arm_ok     = inArm && !in_capt && capt_mode;
    // Only CAPT writes; the FSM leaves CAPT on the DEPTH-th write, so no overflow guard is needed.
    assign write_en   = in_capt && ((mode_reg == MODE_CAPT_ALL) ||
                                    ((mode_reg == MODE_CAPT_VALID) && sel_valid));
    // A legal arm clears the buffer, so it wins over a same-cycle read.
    assign read_en    = inReadEnable && !in_capt && !arm_ok && !buf_empty;

    assign error_next = (inCfgLoad && (in_capt || !cfg_sel_ok)) ||
                        (inArm && !in_capt && !capt_mode) ||
                        (inReadEnable && in_capt) ||
                        (inReadEnable && !in_capt && !arm_ok && buf_empty);

    always_ff @(posedge inClock) begin
        if (inReset) begin
            shadow_reg      <= '0;
            mode_reg        <= MODE_BYPASS;
            sel_reg         <= '0;
            state_reg       <= ST_IDLE;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            probe_reg       <= '0;
            probe_valid_reg <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            error_reg <= error_next;

            if (mode_reg != MODE_FREEZE) begin
                probe_reg       <= sel_data;
                probe_valid_reg <= sel_valid;
            end

            // Load sees the pre-shift shadow when shift and load coincide.
            if (inCfgLoad && !in_capt && cfg_sel_ok) begin
                mode_reg <= shadow_reg[CFG_W-1 -: 2];
                sel_reg  <= shadow_reg[SEL_W-1:0];
            end
            if (inCfgShift) begin
                shadow_reg <= {shadow_reg[CFG_W-2:0], inCfgData};
            end

            case (state_reg)
                ST_CAPT: begin
                    if (write_en) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                        count_reg  <= count_reg + 1'b1;
                        if (count_reg == LAST_WRITE) begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                default: begin
                    if (arm_ok) begin
                        state_reg  <= ST_CAPT;
                        wr_ptr_reg <= '0;
                        rd_ptr_reg <= '0;
                        count_reg  <= '0;
                    end else if (read_en) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                        count_reg  <= count_reg - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge inClock) begin
        if (write_en) begin
            mem[wr_ptr_reg] <= sel_data;
        end
    end

    always_ff @(posedge inClock) begin
        if (inReset) begin
            data_reg <= '0;
        end else if (read_en) begin
            data_reg <= mem[rd_ptr_reg];
        end
    end

    assign outProbe      = probe_reg;
    assign outProbeValid = probe_valid_reg;
    assign outData       = data_reg;
    assign outEmpty      = buf_empty;
    assign outFull       = (count_reg == DEPTH_CNT);
    assign outCount      = count_reg;
    assign outCapturing  = in_capt;
    assign outDone       = (state_reg == ST_DONE);
    assign outError      = error_reg;

endmodule

// File: tb/tb_test_probe_ctrl.sv
// Randomised bench for test_probe_ctrl: a queue-based reference model pushes the expected
// outputs of every edge into a scoreboard, and a monitor compares them on the falling edge.
module tb_test_probe_ctrl;

    localparam int IDLE = 0;
    localparam int CAPT = 1;
    localparam int DONE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_shift = 1'b0;
    logic        cfg_data = 1'b0;
    logic        cfg_load = 1'b0;
    logic [31:0] probe_data = '0;
    logic [7:0]  probe_valid = '0;
    logic        arm = 1'b0;
    logic        rd = 1'b0;

    logic [3:0]  out_probe;
    logic        out_probe_valid;
    logic [3:0]  out_data;
    logic        out_empty;
    logic        out_full;
    logic [4:0]  out_count;
    logic        out_capturing;
    logic        out_done;
    logic        out_error;

    test_probe_ctrl #(.NUM_CH(8), .DATA_W(4), .DEPTH(16)) dut (
        .inClock      (clk),
        .inReset      (rst),
        .inCfgShift   (cfg_shift),
        .inCfgData    (cfg_data),
        .inCfgLoad    (cfg_load),
        .inProbeData  (probe_data),
        .inProbeValid (probe_valid),
        .inArm        (arm),
        .inReadEnable (rd),
        .outProbe     (out_probe),
        .outProbeValid(out_probe_valid),
        .outData      (out_data),
        .outEmpty     (out_empty),
        .outFull      (out_full),
        .outCount     (out_count),
        .outCapturing (out_capturing),
        .outDone      (out_done),
        .outError     (out_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] probe;
        logic       pv;
        logic [3:0] data;
        logic       empty;
        logic       full;
        logic [4:0] count;
        logic       capt;
        logic       done;
        logic       err;
        bit         rd;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: the buffer is simply a FIFO queue.
    int         m_state = IDLE;
    logic [1:0] m_mode = 2'b00;
    int         m_sel = 0;
    logic [4:0] m_shadow = '0;
    logic [3:0] m_buf[$];
    logic [3:0] e_probe = '0;
    logic       e_pv = 1'b0;
    logic [3:0] e_data = '0;

    task automatic model_step();
        exp_t       e;
        logic       err;
        logic [1:0] mode;
        int         sel;
        logic [3:0] chd;
        logic       chv;
        bit         did_rd;
        err = 1'b0;
        did_rd = 1'b0;
        if (rst) begin
            m_state = IDLE;
            m_mode = 2'b00;
            m_sel = 0;
            m_shadow = '0;
            m_buf.delete();
            e_probe = '0;
            e_pv = 1'b0;
            e_data = '0;
        end else begin
            mode = m_mode;
            sel = m_sel;
            chd = probe_data[sel*4 +: 4];
            chv = probe_valid[sel];
            if (mode != 2'b11) begin
                e_probe = chd;
                e_pv = chv;
            end
            if (cfg_load) begin
                if (m_state == CAPT) err = 1'b1;
                else begin
                    m_mode = m_shadow[4:3];
                    m_sel = int'(m_shadow[2:0]);
                end
            end
            if (cfg_shift) m_shadow = {m_shadow[3:0], cfg_data};
            if (m_state == CAPT) begin
                if (rd) err = 1'b1;
                if (mode == 2'b10 || (mode == 2'b01 && chv)) begin
                    m_buf.push_back(chd);
                    if (m_buf.size() == 16) m_state = DONE;
                end
            end else if (arm && (mode == 2'b01 || mode == 2'b10)) begin
                m_state = CAPT;
                m_buf.delete();
            end else begin
                if (arm) err = 1'b1;
                if (rd) begin
                    if (m_buf.size() > 0) begin
                        e_data = m_buf.pop_front();
                        did_rd = 1'b1;
                    end else err = 1'b1;
                end
            end
        end
        e.probe = e_probe;
        e.pv    = e_pv;
        e.data  = e_data;
        e.empty = (m_buf.size() == 0);
        e.full  = (m_buf.size() == 16);
        e.count = 5'(m_buf.size());
        e.capt  = (m_state == CAPT);
        e.done  = (m_state == DONE);
        e.err   = err;
        e.rd    = did_rd;
        sb.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("probe",     32'(out_probe),       32'(e.probe));
            check("probe_vld", 32'(out_probe_valid), 32'(e.pv));
            check("data",      32'(out_data),        32'(e.data));
            check("empty",     32'(out_empty),       32'(e.empty));
            check("full",      32'(out_full),        32'(e.full));
            check("count",     32'(out_count),       32'(e.count));
            check("capturing", 32'(out_capturing),   32'(e.capt));
            check("done",      32'(out_done),        32'(e.done));
            check("error",     32'(out_error),       32'(e.err));
            if (e.rd) $display("[TB] read data=%h expected=%h count=%0d", out_data, e.data, out_count);
        end
    end

    task automatic tick();
        @(negedge clk);
        cfg_shift = 1'b0;
        cfg_load = 1'b0;
        arm = 1'b0;
        rd = 1'b0;
        probe_data = $urandom;
        probe_valid = 8'($urandom);
    endtask

    task automatic shift_cfg(input logic [4:0] c);
        for (int i = 4; i >= 0; i--) begin
            cfg_shift = 1'b1;
            cfg_data = c[i];
            tick();
        end
        cfg_load = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!out_done && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (!out_done) begin
            fails++;
            $display("[TB] FAIL done_timeout: outDone=%0b after %0d cycles, required 1", out_done, n);
        end
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) begin
            rd = 1'b1;
            tick();
        end
    endtask

    initial begin
        int val;
        // Reset with channel 0 driven to A.
        rst = 1'b1;
        probe_data = $urandom;
        probe_data[3:0] = 4'hA;
        @(negedge clk);
        probe_data[3:0] = 4'hA;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Bypass on channel 3, then channel 7.
        shift_cfg(5'b00_011);
        probe_data[15:12] = 4'h5;
        tick();
        tick();
        shift_cfg(5'b00_111);
        tick();
        tick();

        // CAPT_ALL on channel 2 with a ramp.
        shift_cfg(5'b10_010);
        arm = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            probe_data[11:8] = 4'(i);
            tick();
        end
        wait_done(8);
        read_n(17);
        tick();

        // CAPT_VALID on channel 1, valid every third cycle, with in-capture error requests.
        shift_cfg(5'b01_001);
        arm = 1'b1;
        tick();
        val = 1;
        for (int i = 0; i < 100 && !out_done; i++) begin
            probe_valid[1] = (i % 3 == 2);
            probe_data[7:4] = 4'(val);
            if (i % 3 == 2) val++;
            if (i == 10) cfg_load = 1'b1;
            if (i == 20) rd = 1'b1;
            if (i == 30) arm = 1'b1;
            tick();
        end
        wait_done(2);
        read_n(16);

        // Illegal requests outside capture, then FREEZE hold.
        shift_cfg(5'b00_000);
        arm = 1'b1;
        tick();
        rd = 1'b1;
        tick();
        shift_cfg(5'b11_010);
        repeat (4) tick();
        arm = 1'b1;
        tick();
        tick();

        // Reset after seven captured samples, then a fresh capture.
        shift_cfg(5'b10_101);
        arm = 1'b1;
        tick();
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        shift_cfg(5'b10_011);
        arm = 1'b1;
        tick();
        wait_done(30);
        read_n(16);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            cfg_shift = ($urandom_range(0, 2) == 0);
            cfg_data  = 1'($urandom);
            cfg_load  = ($urandom_range(0, 11) == 0);
            arm       = ($urandom_range(0, 14) == 0);
            rd        = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            probe_data  = $urandom;
            probe_valid = 8'($urandom);
        end
        rst = 1'b0;
        cfg_shift = 1'b0;
        cfg_load = 1'b0;
        arm = 1'b0;
        rd = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
